// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared MSHR sizing constants
package toy_pack;

    // Size of the MSHR entry pool
    localparam int MSHR_ENTRY_NUM = 8;

    // Number of miss-request sources competing for entries
    localparam int MSHR_REQ_NUM   = 4;

endpackage

// File: rtl/cmn_lead_one.sv
// rtl/cmn_lead_one.sv - lowest-index set-bit finder
//
// Purpose: reports whether any bit of vec is set and the index of the
//          lowest set bit.
// Ports:
//   vec    in   ENTRY_NUM     vector to search
//   found  out  1             any bit of vec set
//   index  out  INDEX_WIDTH   lowest set bit index (0 when none)
module cmn_lead_one #(
    parameter int ENTRY_NUM   = 8,
    parameter int INDEX_WIDTH = $clog2(ENTRY_NUM)
) (
    input  logic [ENTRY_NUM-1:0]   vec,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] index
);

    always_comb begin
        found = |vec;
        index = '0;
        // Scan downward so the last hit written is the lowest index.
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/cmn_rr_arb.sv
// rtl/cmn_rr_arb.sv - combinational round-robin arbiter
//
// Purpose: picks the first requesting index at or after ptr, wrapping
//          modulo REQ_NUM. The pointer register lives in the caller.
// Ports:
//   req      in   REQ_NUM     request vector
//   ptr      in   REQ_WIDTH   highest-priority index (must be < REQ_NUM)
//   gnt_vld  out  1           some request was granted
//   gnt      out  REQ_NUM     one-hot grant
//   gnt_idx  out  REQ_WIDTH   index of the granted request
module cmn_rr_arb #(
    parameter int REQ_NUM   = 4,
    parameter int REQ_WIDTH = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]   req,
    input  logic [REQ_WIDTH-1:0] ptr,
    output logic                 gnt_vld,
    output logic [REQ_NUM-1:0]   gnt,
    output logic [REQ_WIDTH-1:0] gnt_idx
);

    int                   pos;
    logic [REQ_WIDTH-1:0] sel;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        pos     = 0;
        sel     = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            // ptr < REQ_NUM, so a single subtract implements the wrap.
            pos = int'(ptr) + k;
            if (pos >= REQ_NUM) begin
                pos = pos - REQ_NUM;
            end
            sel = REQ_WIDTH'(pos);
            if (!gnt_vld && req[sel]) begin
                gnt_vld  = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/mshr_alloc_arb.sv
// rtl/mshr_alloc_arb.sv - MSHR free-entry pre-allocation and request arbitration
//
// Purpose: keeps one free MSHR entry reserved in a pre-slot and grants it to
//          one miss requester per cycle in round-robin order. Owns the entry
//          busy bitmap (set on reservation, cleared on release).
// Ports:
//   clk            in   1              clock
//   rst_n          in   1              asynchronous active-low reset
//   v_req_vld      in   REQ_NUM        per-requester allocation request
//   v_req_rdy      out  REQ_NUM        one-hot grant (handshake = vld & rdy)
//   alloc_vld      out  1              an allocation completed last cycle
//   alloc_index    out  INDEX_WIDTH    entry granted
//   alloc_req_id   out  REQ_WIDTH      winning requester
//   v_release_vld  in   ENTRY_NUM      entries freed by the MSHR this cycle
//   v_entry_busy   out  ENTRY_NUM      busy bitmap, including pre-slot entry
//   free_cnt       out  INDEX_WIDTH+1  number of non-busy entries
//   full           out  1              all entries busy and pre-slot empty
module mshr_alloc_arb
    import toy_pack::*;
#(
    parameter int ENTRY_NUM   = MSHR_ENTRY_NUM,
    parameter int REQ_NUM     = MSHR_REQ_NUM,
    parameter int INDEX_WIDTH = $clog2(ENTRY_NUM),
    parameter int REQ_WIDTH   = $clog2(REQ_NUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REQ_NUM-1:0]     v_req_vld,
    output logic [REQ_NUM-1:0]     v_req_rdy,
    output logic                   alloc_vld,
    output logic [INDEX_WIDTH-1:0] alloc_index,
    output logic [REQ_WIDTH-1:0]   alloc_req_id,
    input  logic [ENTRY_NUM-1:0]   v_release_vld,
    output logic [ENTRY_NUM-1:0]   v_entry_busy,
    output logic [INDEX_WIDTH:0]   free_cnt,
    output logic                   full
);

    localparam logic [0:0]           SLOT_EMPTY = 1'b0;
    localparam logic [0:0]           SLOT_HELD  = 1'b1;
    localparam logic [ENTRY_NUM-1:0] ENTRY_ONE  = ENTRY_NUM'(1);

    logic [0:0]             slot_state;
    logic [INDEX_WIDTH-1:0] slot_idx;
    logic [ENTRY_NUM-1:0]   busy;
    logic [REQ_WIDTH-1:0]   rr_ptr;

    logic                   held;
    logic [ENTRY_NUM-1:0]   free_vec;
    logic                   free_found;
    logic [INDEX_WIDTH-1:0] free_idx;
    logic [REQ_NUM-1:0]     arb_req;
    logic                   grant;
    logic [REQ_NUM-1:0]     arb_gnt;
    logic [REQ_WIDTH-1:0]   arb_idx;
    logic [ENTRY_NUM-1:0]   slot_mask;
    logic [ENTRY_NUM-1:0]   rel_eff;
    logic                   load;
    logic [ENTRY_NUM-1:0]   load_mask;
    logic [ENTRY_NUM-1:0]   busy_nxt;

    assign held     = (slot_state == SLOT_HELD);
    // The pre-slot entry is already marked busy, so it never shows up here.
    assign free_vec = ~busy;

    cmn_lead_one #(
        .ENTRY_NUM   (ENTRY_NUM),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_free_pick (
        .vec   (free_vec),
        .found (free_found),
        .index (free_idx)
    );

    // Requests are only eligible while an entry sits in the pre-slot.
    assign arb_req = held ? v_req_vld : '0;

    cmn_rr_arb #(
        .REQ_NUM   (REQ_NUM),
        .REQ_WIDTH (REQ_WIDTH)
    ) u_rr_arb (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt_vld (grant),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign v_req_rdy = arb_gnt;

    // Releases of idle entries or of the reserved pre-slot entry are dropped.
    assign slot_mask = held ? (ENTRY_ONE << slot_idx) : '0;
    assign rel_eff   = v_release_vld & busy & ~slot_mask;

    // Refill the pre-slot when it is empty or being handed out this cycle.
    // The search uses the pre-edge bitmap, so same-cycle releases wait.
    assign load      = free_found && (!held || grant);
    assign load_mask = load ? (ENTRY_ONE << free_idx) : '0;
    assign busy_nxt  = (busy & ~rel_eff) | load_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_state   <= SLOT_EMPTY;
            slot_idx     <= '0;
            busy         <= '0;
            rr_ptr       <= '0;
            alloc_vld    <= 1'b0;
            alloc_index  <= '0;
            alloc_req_id <= '0;
        end else begin
            busy      <= busy_nxt;
            alloc_vld <= grant;
            if (load) begin
                slot_state <= SLOT_HELD;
                slot_idx   <= free_idx;
            end else if (grant) begin
                slot_state <= SLOT_EMPTY;
            end
            if (grant) begin
                alloc_index  <= slot_idx;
                alloc_req_id <= arb_idx;
                rr_ptr       <= (arb_idx == REQ_WIDTH'(REQ_NUM - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    assign v_entry_busy = busy;
    assign full         = (&busy) && !held;

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            free_cnt = free_cnt + {{INDEX_WIDTH{1'b0}}, free_vec[i]};
        end
    end

    a_release_legal: assert property (
        @(posedge clk) disable iff (!rst_n)
        (v_release_vld & ~(busy & ~slot_mask)) == '0
    );

endmodule

// File: tb/tb_mshr_alloc_arb.sv
// tb/tb_mshr_alloc_arb.sv - scoreboard testbench for mshr_alloc_arb
module tb_mshr_alloc_arb;
    import toy_pack::*;

    localparam int EN = MSHR_ENTRY_NUM;
    localparam int RN = MSHR_REQ_NUM;
    localparam int IW = $clog2(EN);
    localparam int RW = $clog2(RN);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RN-1:0] v_req_vld = '0;
    logic [RN-1:0] v_req_rdy;
    logic          alloc_vld;
    logic [IW-1:0] alloc_index;
    logic [RW-1:0] alloc_req_id;
    logic [EN-1:0] v_release_vld = '0;
    logic [EN-1:0] v_entry_busy;
    logic [IW:0]   free_cnt;
    logic          full;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int c;
        int idx;
        int id;
    } exp_t;
    exp_t sb[$];

    // Reference model: entries handed to the MSHR, the reserved entry
    // (-1 when none) and the next requester in line.
    bit busy_m[EN];
    int slot_m = -1;
    int ptr_m  = 0;

    mshr_alloc_arb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .v_req_vld     (v_req_vld),
        .v_req_rdy     (v_req_rdy),
        .alloc_vld     (alloc_vld),
        .alloc_index   (alloc_index),
        .alloc_req_id  (alloc_req_id),
        .v_release_vld (v_release_vld),
        .v_entry_busy  (v_entry_busy),
        .free_cnt      (free_cnt),
        .full          (full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < EN; i++) busy_m[i] = 1'b0;
        slot_m = -1;
        ptr_m  = 0;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_rdy"}, int'(v_req_rdy), 0);
        chk({tag, "_alloc_vld"}, int'(alloc_vld), 0);
        chk({tag, "_alloc_index"}, int'(alloc_index), 0);
        chk({tag, "_alloc_req_id"}, int'(alloc_req_id), 0);
        chk({tag, "_busy"}, int'(v_entry_busy), 0);
        chk({tag, "_free_cnt"}, int'(free_cnt), EN);
        chk({tag, "_full"}, int'(full), 0);
    endtask

    // Called just after a rising edge; reset is applied mid-cycle.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        reset_values(tag);
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: apply inputs, check the combinational view against
    // the model, record any expected allocation, then advance the model.
    task automatic step(input logic [RN-1:0] req, input logic [EN-1:0] rel);
        int gid;
        int lowest;
        int exp_busy;
        int exp_free;
        bit all_taken;
        v_req_vld     = req;
        v_release_vld = rel;
        @(negedge clk);
        gid = -1;
        if (slot_m >= 0) begin
            for (int k = 0; k < RN; k++) begin
                int r;
                r = (ptr_m + k) % RN;
                if (gid < 0 && req[r]) gid = r;
            end
        end
        exp_busy  = 0;
        exp_free  = 0;
        all_taken = 1'b1;
        lowest    = -1;
        for (int i = 0; i < EN; i++) begin
            if (busy_m[i] || i == slot_m) exp_busy |= (1 << i);
            else exp_free++;
            if (!busy_m[i]) all_taken = 1'b0;
            if (lowest < 0 && !busy_m[i] && i != slot_m) lowest = i;
        end
        chk("rdy", int'(v_req_rdy), (gid >= 0) ? (1 << gid) : 0);
        chk("busy", int'(v_entry_busy), exp_busy);
        chk("free_cnt", int'(free_cnt), exp_free);
        chk("full", int'(full), (slot_m < 0 && all_taken) ? 1 : 0);
        if (gid >= 0) begin
            sb.push_back('{c: cyc, idx: slot_m, id: gid});
            busy_m[slot_m] = 1'b1;
            ptr_m  = (gid + 1) % RN;
            slot_m = lowest;
        end else if (slot_m < 0) begin
            slot_m = lowest;
        end
        for (int i = 0; i < EN; i++) begin
            if (rel[i]) busy_m[i] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Random subset of entries currently owned by the MSHR.
    function automatic logic [EN-1:0] rand_rel(input int pct);
        logic [EN-1:0] v;
        v = '0;
        for (int i = 0; i < EN; i++) begin
            if (busy_m[i] && ($urandom_range(0, 99) < pct)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Monitor: every alloc pulse must match the oldest outstanding grant,
    // exactly one cycle after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (alloc_vld) begin
                    if (sb.size() == 0) begin
                        chk("alloc_spurious", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("alloc_latency", cyc - e.c, 1);
                        chk("alloc_index", int'(alloc_index), e.idx);
                        chk("alloc_req_id", int'(alloc_req_id), e.id);
                    end
                end else if (sb.size() > 0 && sb[0].c < cyc) begin
                    e = sb.pop_front();
                    chk("alloc_missing", 0, 1);
                end
            end
        end
    end

    initial begin
        model_reset();
        #1;
        reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First edge after reset reserves entry 0.
        step('0, '0);
        chk("post_reset_busy", int'(v_entry_busy), 1);
        chk("post_reset_free_cnt", int'(free_cnt), EN - 1);

        // Single requester drains the pool in index order.
        repeat (10) step(RN'(1), '0);
        chk("drained_full", int'(full), 1);
        chk("drained_rdy", int'(v_req_rdy), 0);

        // All requesters from a fresh reset: ids rotate, indices ascend.
        do_reset("reset2");
        repeat (11) step({RN{1'b1}}, '0);
        chk("all_req_full", int'(full), 1);

        // Exhausted pool, release entry 5: free at T+1, reserved at T+2.
        step('0, EN'(1 << 5));
        chk("rel5_freed", int'(v_entry_busy[5]), 0);
        chk("rel5_full", int'(full), 0);
        step('0, '0);
        chk("rel5_reserved", int'(v_entry_busy[5]), 1);
        step(RN'(1), '0);
        step('0, '0);

        // Reserve entry 7, then hand it out while releasing 2 and 6.
        step('0, EN'(1 << 7));
        step('0, '0);
        step(RN'(2), EN'((1 << 2) | (1 << 6)));
        repeat (5) step(RN'(2), '0);

        // Randomised traffic with random legal releases.
        repeat (400) step(RN'($urandom_range(0, (1 << RN) - 1)), rand_rel(25));

        // Reset in the middle of a burst, then restart cleanly.
        step('0, rand_rel(100));
        repeat (4) step({RN{1'b1}}, '0);
        do_reset("mid_reset");
        repeat (6) step({RN{1'b1}}, '0);
        repeat (200) step(RN'($urandom_range(0, (1 << RN) - 1)), rand_rel(30));

        repeat (3) step('0, '0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
